bcd_seg_scan: RTL and testbench
===============================

// Module: bcd_seg_scan
// PURPOSE
//  Multiplexed 7-segment display driver; consumes packed BCD from b2bd (tens in [7:4], ones in [3:0]).
//  Scans DIGITS digits with a prescaled refresh tick and drives active-low segments and anodes.
//  Double-buffers the input so a new value is applied only at a frame boundary (no tearing).
//  Last stage before board pins.
// PARAMETERS
//  DIGITS    2  number of BCD digits / anodes; digit 0 = least significant = bcd_in[3:0]
//  PRESCALE  4  clk cycles per digit slot (>=1); a frame lasts DIGITS*PRESCALE cycles
// PORTS
//  clk         in   1           system clock, rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  load        in   1           capture bcd_in on this edge
//  bcd_in      in   4*DIGITS    packed BCD digits
//  blank_lz    in   1           1 = blank leading zeros
//  seg         out  7           segments {g,f,e,d,c,b,a}, active low, registered
//  an          out  DIGITS      anodes, active low one-hot, registered
//  frame_done  out  1           one-cycle pulse when the scan wraps to digit 0
//  pending     out  1           1 = captured value waiting for the next frame boundary
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low.
//  Reset (async, immediate, incl. mid-frame): seg=7'h7F, an=all 1, frame_done=0, pending=0,
//   shadow=0, disp=0, prescale cnt=0, digit idx=0.
//  Prescaler cnt counts 0..PRESCALE-1; tick = (cnt==PRESCALE-1); cnt then returns to 0.
//  On tick: idx <= idx+1, wrapping DIGITS-1 -> 0; wrap tick = tick && idx==DIGITS-1.
//  frame_done registered: 1 for exactly the cycle after the wrap tick edge.
//  load=1 (no wrap tick): shadow <= bcd_in, pending <= 1; repeated loads overwrite (last wins).
//  Wrap tick, pending=1, load=0: disp <= shadow, pending <= 0.
//  Wrap tick with load=1: disp <= bcd_in directly (bypass), shadow <= bcd_in, pending <= 0.
//  Wrap tick, pending=0, load=0: disp unchanged.
//  Outputs registered from current idx/disp: an[idx]=0, others 1; latency 1 cycle after idx change.
//  Decode (active low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex);
//   nibble 10..15 = dash 7'h3F.
//  Leading-zero blank: if blank_lz, digit k>0 shows 7'h7F when disp digits k..DIGITS-1 are all 0;
//   an still driven. Digit 0 is never blanked. Invalid nibbles count as non-zero.
//  blank_lz is sampled combinationally each cycle (not double-buffered).
// STRUCTURE
//  Shared include seg7_defs.vh: SEG_OFF=7'h7F, SEG_DASH=7'h3F, digit-pattern constants 0..9.
//  Sub-module seg7_dec: 4-bit nibble -> 7-bit active-low pattern (pure combinational).
//  Top: prescaler, idx counter, shadow/disp regs + pending flag, digit mux, blank logic, out regs.
// TESTING  (DIGITS=2, PRESCALE=4)
//  Reset: rst_n=0 mid-scan -> seg=7'h7F, an=2'b11, pending=0 without waiting for a clk edge.
//  Load 8'h42, wait frame_done -> slot0: an=2'b10 seg=7'h24; slot1: an=2'b01 seg=7'h19;
//   each slot lasts 4 cycles.
//  Load 8'h15 while idx=1 -> pending=1, display keeps old value until wrap,
//   then shows 1/5 and pending=0.
//  blank_lz=1, show 8'h07 -> digit1 seg=7'h7F, digit0 seg=7'h78;
//   blank_lz=0 -> digit1 seg=7'h40.
//  Show 8'hA3 -> digit1 seg=7'h3F (dash), digit0 seg=7'h30.
//  Load 8'h99 on the wrap-tick edge -> next frame shows 9/9, pending stays 0.
//  Loads 8'h11 then 8'h22 within one frame -> only 2/2 is displayed.

Source files
------------

// File: rtl/bcd_seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner. Segment patterns
// are active low and ordered {g,f,e,d,c,b,a}.
package bcd_seg_scan_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF  = 7'h7F;
  localparam seg_t SEG_DASH = 7'h3F;

  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_seg_scan_seg7_dec.sv
// Nibble to active-low 7-segment pattern. Non-BCD codes show a dash so a
// corrupted input is visible on the display rather than silently hidden.
module seg7_dec
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  always_comb begin
    case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed BCD display driver: prescaled digit scan, frame-synchronous
// double buffering of the input value, leading-zero blanking, registered pins.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BCD_W-1:0]  shadow_q, shadow_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              pending_q, pending_d;
  logic              frame_done_q;
  seg_t              seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              tick;
  logic              wrap;
  logic [3:0]        cur_nib;
  logic              cur_blank;
  logic              lead_zero;
  seg_t              dec_seg;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == IDX_MAX);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
  end

  // The displayed value only changes on the wrap tick; a load on that very
  // edge bypasses the shadow so it is not delayed by a whole frame.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (wrap) begin
      if (load) begin
        disp_d   = bcd_in;
        shadow_d = bcd_in;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end
  end

  // Walk from the most significant digit down so lead_zero at digit k means
  // digits k..DIGITS-1 are all zero.
  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    an_d      = '1;
    lead_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lead_zero = lead_zero && (disp_q[4*k +: 4] == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = disp_q[4*k +: 4];
        cur_blank = blank_lz && lead_zero && (k != 0);
        an_d[k]   = 1'b0;
      end
    end
  end

  seg7_dec u_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  assign seg_d = cur_blank ? SEG_OFF : dec_seg;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; all of it is plain flops, so all of it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      frame_done_q <= wrap;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (DIGITS=2, PRESCALE=4): vector table,
// hand-written frame-boundary sequences and random traffic against a model.
module tb_bcd_seg_scan;

  localparam int DIG   = 2;
  localparam int PRE   = 4;
  localparam int FRAME = DIG * PRE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] bcd_in = 8'h00;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;
  logic       pending;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: cycle count since reset release plus the two buffers.
  int         m_cyc;
  logic [7:0] m_disp;
  logic [7:0] m_shadow;
  logic       m_pending;
  logic       cur_blz;

  typedef struct {
    logic [7:0] bcd;
    logic       blz;
    logic [6:0] seg0;
    logic [6:0] seg1;
  } vec_t;

  vec_t vecs[10];

  bcd_seg_scan #(.DIGITS(DIG), .PRESCALE(PRE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .bcd_in     (bcd_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [7:0] disp, input int idx, input logic blz);
    int nib;
    nib = int'((disp >> (4 * idx)) & 8'h0F);
    if (blz && idx > 0 && (disp >> (4 * idx)) == 8'h00) return 7'h7F;
    case (nib)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic reset_model();
    m_cyc     = 0;
    m_disp    = 8'h00;
    m_shadow  = 8'h00;
    m_pending = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, advance the model one rising
  // edge, then compare all outputs at the next falling edge.
  task automatic step(input logic ld, input logic [7:0] val, input logic blz);
    int         idx;
    logic       wrap;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    load     = ld;
    bcd_in   = val;
    blank_lz = blz;
    idx   = (m_cyc / PRE) % DIG;
    wrap  = (m_cyc % FRAME) == FRAME - 1;
    e_seg = ref_seg(m_disp, idx, blz);
    e_an  = 2'b11 ^ (2'b01 << idx);
    if (wrap) begin
      if (ld) begin
        m_disp   = val;
        m_shadow = val;
      end else if (m_pending) begin
        m_disp = m_shadow;
      end
      m_pending = 1'b0;
    end else if (ld) begin
      m_shadow  = val;
      m_pending = 1'b1;
    end
    m_cyc++;
    @(posedge clk);
    @(negedge clk);
    check("seg", seg, e_seg);
    check("an", an, e_an);
    check("frame_done", frame_done, wrap);
    check("pending", pending, m_pending);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, cur_blz);
  endtask

  task automatic wait_frame(input string name);
    logic seen;
    seen = frame_done;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      idle();
      seen = frame_done;
    end
    check({name, "_frame_wait"}, seen, 1'b1);
  endtask

  // Must start right after the frame_done cycle: two slots of PRE cycles.
  task automatic show_frame(input string name, input logic [6:0] s0, input logic [6:0] s1);
    for (int i = 0; i < PRE; i++) begin
      idle();
      check({name, "_slot0_an"}, an, 2'b10);
      check({name, "_slot0_seg"}, seg, s0);
    end
    for (int i = 0; i < PRE; i++) begin
      idle();
      check({name, "_slot1_an"}, an, 2'b01);
      check({name, "_slot1_seg"}, seg, s1);
    end
  endtask

  initial begin
    vecs[0] = '{8'h42, 1'b0, 7'h24, 7'h19};
    vecs[1] = '{8'h07, 1'b1, 7'h78, 7'h7F};
    vecs[2] = '{8'h07, 1'b0, 7'h78, 7'h40};
    vecs[3] = '{8'hA3, 1'b0, 7'h30, 7'h3F};
    vecs[4] = '{8'h00, 1'b1, 7'h40, 7'h7F};
    vecs[5] = '{8'h99, 1'b1, 7'h10, 7'h10};
    vecs[6] = '{8'hF0, 1'b1, 7'h40, 7'h3F};
    vecs[7] = '{8'h60, 1'b1, 7'h40, 7'h02};
    vecs[8] = '{8'h08, 1'b1, 7'h00, 7'h7F};
    vecs[9] = '{8'h58, 1'b0, 7'h00, 7'h12};
    cur_blz = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("reset_seg", seg, 7'h7F);
    check("reset_an", an, 2'b11);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_pending", pending, 1'b0);
    reset_model();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cur_blz = vecs[i].blz;
      step(1'b1, vecs[i].bcd, cur_blz);
      wait_frame("vec");
      show_frame($sformatf("vec%0d", i), vecs[i].seg0, vecs[i].seg1);
    end

    // Load during slot 1: old value (58) holds until the wrap, then 15.
    for (int i = 0; i < PRE; i++) idle();
    step(1'b1, 8'h15, cur_blz);
    check("midframe_pending", pending, 1'b1);
    for (int i = 0; i < PRE - 1; i++) begin
      check("midframe_old_seg", seg, 7'h12);
      idle();
    end
    wait_frame("midframe");
    check("midframe_pending_clr", pending, 1'b0);
    show_frame("midframe", 7'h12, 7'h79);

    // Load on the wrap-tick edge bypasses the shadow.
    for (int i = 0; i < FRAME - 1; i++) idle();
    step(1'b1, 8'h99, cur_blz);
    check("bypass_pending", pending, 1'b0);
    check("bypass_frame_done", frame_done, 1'b1);
    show_frame("bypass", 7'h10, 7'h10);

    // Two loads in one frame: last one wins.
    step(1'b1, 8'h11, cur_blz);
    idle();
    step(1'b1, 8'h22, cur_blz);
    check("double_pending", pending, 1'b1);
    wait_frame("double");
    show_frame("double", 7'h24, 7'h24);

    // Asynchronous reset in the middle of a frame with a value pending.
    step(1'b1, 8'h37, cur_blz);
    idle();
    check("prereset_pending", pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_seg", seg, 7'h7F);
    check("async_an", an, 2'b11);
    check("async_pending", pending, 1'b0);
    check("async_frame_done", frame_done, 1'b0);
    @(negedge clk);
    reset_model();
    rst_n = 1'b1;
    idle();

    // Random traffic; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      logic       ld;
      logic [7:0] val;
      ld  = ($urandom_range(0, 5) == 0);
      val = 8'($urandom);
      if ($urandom_range(0, 1) == 1) val[7:4] = 4'h0;
      if ($urandom_range(0, 3) == 0) val[3:0] = 4'h0;
      if ($urandom_range(0, 19) == 0) cur_blz = ~cur_blz;
      step(ld, val, cur_blz);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
